// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: byte-level front end for the LCD write-cycle stage.
// Splits each command/data byte into high/low nibbles for a 4-bit HD44780 bus,
// handshakes each nibble with the write-cycle stage, then holds off the next
// byte for the controller's execution time.
// Optional feature macro: LCD_INIT_SEQ_EN -- when defined, the power-on wait
// and the 4-bit init sequence run after every reset; when undefined the block
// comes out of reset idle and the application sends the init bytes itself.
module lcd_cmd_sequencer #(
    parameter int DLY_POWERUP = 750000,
    parameter int DLY_LONG    = 82000,
    parameter int DLY_SHORT   = 2000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       wr_enable,
    output logic       reg_sel,
    output logic [3:0] db_out,
    input  logic       wr_finish
);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_WR_HI, S_GAP, S_WR_LO, S_DLY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             single;     // current write is a lone init nibble
    logic [CNT_W-1:0] dly_last;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] step;             // 0..3 init nibbles, 4..7 init bytes

    function automatic logic [3:0] init_nib(input logic [2:0] s);
        return (s == 3'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    // Execution delay: clear/home style commands (and init nibbles) need the long wait
    always_comb begin
        dly_last = CNT_W'(DLY_SHORT - 1);
        if (single || (!rs_q && (data_q inside {8'h01, 8'h02, 8'h03})))
            dly_last = CNT_W'(DLY_LONG - 1);
    end

    // Sequencer FSM with registered outputs; counter cleared on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_SEQ_EN
            state <= S_PWR;
            step  <= 3'd0;
`else
            state <= S_IDLE;
`endif
            cnt       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            wr_enable <= 1'b0;
            reg_sel   <= 1'b0;
            db_out    <= 4'h0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            single    <= 1'b0;
        end else begin
`ifndef LCD_INIT_SEQ_EN
            init_done <= 1'b1;
`endif
            case (state)
`ifdef LCD_INIT_SEQ_EN
                S_PWR: begin
                    if (cnt == CNT_W'(DLY_POWERUP - 1)) begin
                        state <= S_INIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT: begin
                    rs_q      <= 1'b0;
                    reg_sel   <= 1'b0;
                    wr_enable <= 1'b1;
                    cnt       <= '0;
                    state     <= S_WR_HI;
                    if (!step[2]) begin
                        single <= 1'b1;
                        data_q <= {4'h0, init_nib(step)};
                        db_out <= init_nib(step);
                    end else begin
                        single <= 1'b0;
                        data_q <= init_byte(step[1:0]);
                        db_out <= init_byte(step[1:0]) >> 4;
                    end
                end
`endif
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        rs_q      <= req_rs;
                        data_q    <= req_data;
                        single    <= 1'b0;
                        req_ready <= 1'b0;
                        wr_enable <= 1'b1;
                        reg_sel   <= req_rs;
                        db_out    <= req_data[7:4];
                        cnt       <= '0;
                        state     <= S_WR_HI;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WR_HI: begin
                    if (wr_finish) begin
                        wr_enable <= 1'b0;
                        cnt       <= '0;
                        state     <= single ? S_DLY : S_GAP;
                    end
                end
                S_GAP: begin
                    wr_enable <= 1'b1;
                    db_out    <= data_q[3:0];
                    cnt       <= '0;
                    state     <= S_WR_LO;
                end
                S_WR_LO: begin
                    if (wr_finish) begin
                        wr_enable <= 1'b0;
                        cnt       <= '0;
                        state     <= S_DLY;
                    end
                end
                S_DLY: begin
                    if (cnt == dly_last) begin
                        cnt <= '0;
`ifdef LCD_INIT_SEQ_EN
                        if (!init_done) begin
                            step <= step + 3'd1;
                            if (step == 3'd7) begin
                                init_done <= 1'b1;
                                req_ready <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                state <= S_INIT;
                            end
                        end else begin
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
`else
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    wr_enable <= 1'b0;
                    cnt       <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with a small write-cycle stage model
// (wr_finish pulses three cycles after wr_enable rises).
module tb_lcd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, wr_enable, reg_sel;
    logic [3:0] db_out;
    logic       wr_finish = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   age = 0;
    logic hold_mode = 1'b0;

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .DLY_POWERUP(20), .DLY_LONG(10), .DLY_SHORT(4), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
        .wr_enable(wr_enable), .reg_sel(reg_sel), .db_out(db_out),
        .wr_finish(wr_finish)
    );

    // Write-cycle stage model, evaluated away from the active edge
    always @(negedge clk) begin
        if (rst || !wr_enable || wr_finish) begin
            wr_finish = 1'b0;
            age = 0;
        end else if (age == 2) begin
            wr_finish = 1'b1;
        end else begin
            age = age + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; in hold mode keep scrambling the request byte
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            if (hold_mode) req_data = req_data + 8'h11;
        end
    endtask

    // One byte through the full nibble/handshake/delay path, hand-timed
    task automatic send_byte(input logic rs, input logic [7:0] d, input int dly, input logic issue);
        if (issue) begin
            req_valid = 1'b1; req_rs = rs; req_data = d;
            tick();
            if (!hold_mode) req_valid = 1'b0;
        end
        chk("hi_wen", wr_enable, 1);
        chk("hi_db", db_out, d[7:4]);
        chk("hi_rs", reg_sel, rs);
        chk("busy_rdy", req_ready, 0);
        tick(2);
        chk("hi_hold", {wr_enable, reg_sel, db_out}, {1'b1, rs, d[7:4]});
        tick();
        chk("gap", wr_enable, 0);
        tick();
        chk("lo_wen", wr_enable, 1);
        chk("lo_db", db_out, d[3:0]);
        tick(3);
        chk("dly_start", {wr_enable, req_ready}, 2'b00);
        chk("dly_db", db_out, d[3:0]);
        tick(dly - 1);
        chk("dly_end", req_ready, 0);
        tick();
        chk("idle_rdy", req_ready, 1);
    endtask

`ifdef LCD_INIT_SEQ_EN
    logic [3:0] exp_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

    // Called right after rst drops: power-up wait, then the nibble stream
    task automatic init_check();
        int         first = -1;
        int         n = 0;
        logic       prev = 1'b0;
        logic       rs_bad = 1'b0;
        logic [3:0] got [12];
        chk("init_low", init_done, 0);
        for (int i = 0; i < 800; i++) begin
            tick();
            if (wr_enable && !prev) begin
                if (first < 0) first = i;
                if (n < 12) got[n] = db_out;
                n++;
                if (reg_sel) rs_bad = 1'b1;
            end
            prev = wr_enable;
            if (req_ready) break;
        end
        chk("pwr_wait", first, 20);
        chk("nib_count", n, 12);
        for (int k = 0; k < 12; k++) chk("init_nib", got[k], exp_nib[k]);
        chk("init_rs", rs_bad, 0);
        chk("init_done", init_done, 1);
        chk("init_rdy", req_ready, 1);
    endtask
`else
    // Called right after rst drops: immediately idle, nothing written on its own
    task automatic noinit_check();
        logic seen = 1'b0;
        tick();
        chk("ni_rdy", req_ready, 1);
        chk("ni_done", init_done, 1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wr_enable) seen = 1'b1;
        end
        chk("ni_nowr", seen, 0);
    endtask
`endif

    initial begin
        tick(3);
        chk("rst_vals", {req_ready, init_done, wr_enable, reg_sel, db_out}, 8'h00);
        rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_check();
`else
        noinit_check();
`endif
        // data byte, short delay
        send_byte(1'b1, 8'h41, 4, 1'b1);
        // clear-class commands take the long delay; same bytes as data do not
        send_byte(1'b0, 8'h01, 10, 1'b1);
        send_byte(1'b1, 8'h01, 4, 1'b1);
        send_byte(1'b0, 8'h03, 10, 1'b1);
        send_byte(1'b0, 8'h04, 4, 1'b1);
        // request held high with changing data: only the first byte goes out
        hold_mode = 1'b1;
        send_byte(1'b1, 8'h7E, 4, 1'b1);
        hold_mode = 1'b0;
        req_rs = 1'b0; req_data = 8'hA5;
        tick();
        req_valid = 1'b0;
        send_byte(1'b0, 8'hA5, 4, 1'b0);
        // reset during the low-nibble write
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        tick(4);
        chk("pre_rst_lo", {wr_enable, db_out}, 5'h1C);
        rst = 1'b1;
        tick();
        chk("mid_rst", {req_ready, init_done, wr_enable, reg_sel, db_out}, 8'h00);
        rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_check();
`else
        noinit_check();
`endif
        send_byte(1'b1, 8'h5A, 4, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
